// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared constants for the program-loader encoder: MIPS opcode (OP_*) and
// function (FN_*) fields, the REGIMM rt selector used by BGEZ, the loader's
// mnemonic codes (MN_*), the encoder FSM state type and small word-packing
// helpers used by instr_pack.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  // Encoder session states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } enc_state_t;

  // Primary opcodes
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // REGIMM rt selector for BGEZ
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // Loader mnemonic codes; 24..31 are illegal
  localparam logic [4:0] MN_ADD   = 5'd0;
  localparam logic [4:0] MN_ADDU  = 5'd1;
  localparam logic [4:0] MN_SUB   = 5'd2;
  localparam logic [4:0] MN_SUBU  = 5'd3;
  localparam logic [4:0] MN_AND   = 5'd4;
  localparam logic [4:0] MN_OR    = 5'd5;
  localparam logic [4:0] MN_NOR   = 5'd6;
  localparam logic [4:0] MN_SLL   = 5'd7;
  localparam logic [4:0] MN_SRL   = 5'd8;
  localparam logic [4:0] MN_SRA   = 5'd9;
  localparam logic [4:0] MN_SLT   = 5'd10;
  localparam logic [4:0] MN_JR    = 5'd11;
  localparam logic [4:0] MN_ADDI  = 5'd12;
  localparam logic [4:0] MN_ADDIU = 5'd13;
  localparam logic [4:0] MN_ANDI  = 5'd14;
  localparam logic [4:0] MN_BEQ   = 5'd15;
  localparam logic [4:0] MN_BNE   = 5'd16;
  localparam logic [4:0] MN_BGTZ  = 5'd17;
  localparam logic [4:0] MN_BGEZ  = 5'd18;
  localparam logic [4:0] MN_LUI   = 5'd19;
  localparam logic [4:0] MN_LW    = 5'd20;
  localparam logic [4:0] MN_ORI   = 5'd21;
  localparam logic [4:0] MN_SLTI  = 5'd22;
  localparam logic [4:0] MN_SW    = 5'd23;

  // Pack an R-type word
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_R_TYPE, rs, rt, rd, sh, fn};
  endfunction

  // Pack an I-type word
  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational mnemonic + field packer. Produces the 32-bit MIPS word
// for a legal mnemonic and flags illegal codes (24..31). Fields that a given
// instruction format fixes (shamt of non-shift R-type, rs of shifts, rt/rd/
// shamt of JR, rs of LUI, rt of BGTZ/BGEZ) are overridden silently.
//   mnem        : mnemonic code (MN_*)
//   rs/rt/rd    : register fields
//   shamt       : shift amount
//   imm         : 16-bit immediate / offset
//   word        : encoded instruction (0 when illegal)
//   legal       : mnemonic is one of the 24 supported codes
// -----------------------------------------------------------------------------
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Mnemonic decode and field packing
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (mnem)
      MN_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      MN_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      MN_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      MN_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      MN_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      MN_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      MN_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      MN_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      MN_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      MN_SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      MN_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      MN_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      MN_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
      MN_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
      MN_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:   word = i_word(OP_BNE, rs, rt, imm);
      MN_BGTZ:  word = i_word(OP_BGTZ, rs, 5'd0, imm);
      MN_BGEZ:  word = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
      MN_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
      MN_LW:    word = i_word(OP_LW, rs, rt, imm);
      MN_ORI:   word = i_word(OP_ORI, rs, rt, imm);
      MN_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
      MN_SW:    word = i_word(OP_SW, rs, rt, imm);
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Program-loader encoder. Accepts one mnemonic + fields per in_valid/in_ready
// handshake, packs it via instr_pack and writes the word to instruction memory
// at consecutive word addresses starting at BASE_ADDR.
//   clk, rst_n          : clock, synchronous active-low reset
//   start / stop        : begin(restart) / end a load session (1-cycle pulses)
//   in_valid / in_ready : field handshake
//   mnem, rs, rt, rd,
//   shamt, imm          : instruction fields
//   imem_we / imem_ack  : write request, held until acknowledged
//   imem_addr/imem_wdata: byte address / encoded word, stable while imem_we
//   count               : words written this session
//   busy / full / err   : session active / DEPTH reached / illegal mnemonic seen
// All outputs are registered; in_ready never depends on in_valid.
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256,
  localparam int COUNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         mnem,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  input  logic [4:0]         shamt,
  input  logic [15:0]        imm,
  output logic               imem_we,
  input  logic               imem_ack,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               full,
  output logic               err
);

  localparam logic [ADDR_W-1:0]  BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [COUNT_W-1:0] DEPTH_C   = COUNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  WORD_STEP = ADDR_W'(4);

  enc_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;
  logic               stop_pend_q, stop_pend_d;
  logic               in_ready_q, in_ready_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               full_q, full_d;

  logic [31:0]        pack_word;
  logic               pack_legal;

  instr_pack u_pack (
    .mnem  (mnem),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .shamt (shamt),
    .imm   (imm),
    .word  (pack_word),
    .legal (pack_legal)
  );

  // Next-state, address/count and output-register computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;

    if (start) begin
      // start wins over everything, including an outstanding write
      state_d     = ST_RUN;
      addr_d      = BASE_A;
      count_d     = {COUNT_W{1'b0}};
      err_d       = 1'b0;
      stop_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (in_valid) begin
            if (pack_legal) begin
              // a stop arriving with a legal word lets that word complete first
              wdata_d     = pack_word;
              state_d     = ST_WRITE;
              stop_pend_d = stop;
            end else begin
              err_d   = 1'b1;
              state_d = stop ? ST_IDLE : ST_RUN;
            end
          end else if (stop) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            addr_d      = addr_q + WORD_STEP;
            count_d     = count_q + COUNT_W'(1);
            stop_pend_d = 1'b0;
            if (stop_pend_q || stop) begin
              state_d = ST_IDLE;
            end else if (count_d == DEPTH_C) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_RUN;
            end
          end else if (stop) begin
            stop_pend_d = 1'b1;
          end else begin
            stop_pend_d = stop_pend_q;
          end
        end
        ST_FULL: begin
          state_d = ST_FULL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    in_ready_d = (state_d == ST_RUN);
    we_d       = (state_d == ST_WRITE);
    busy_d     = (state_d == ST_RUN) || (state_d == ST_WRITE);
    full_d     = (state_d == ST_FULL);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE_A;
      wdata_q     <= 32'h0000_0000;
      count_q     <= {COUNT_W{1'b0}};
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench: directed program-load scenarios followed by randomized
// sessions. Expected words come from a table-driven reference encoder built
// from the MIPS field layout; address/count/flags come from a small session
// model. BASE_ADDR sits near the top of the address space so sessions wrap.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 'h3F8;
  localparam int DEPTH     = 4;
  localparam int CW        = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n, start, stop, in_valid, imem_ack;
  logic [4:0]        mnem, rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic              in_ready, imem_we, busy, full, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [CW-1:0]     count;

  int checks   = 0;
  int failures = 0;

  // session model
  int m_addr, m_count;
  bit m_err;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .imem_we(imem_we), .imem_ack(imem_ack), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .busy(busy), .full(full), .err(err)
  );

  // funct for mnemonics 0..11, opcode for mnemonics 12..23
  localparam int FN_TAB [12] = '{32, 33, 34, 35, 36, 37, 39, 0, 2, 3, 42, 8};
  localparam int OP_TAB [12] = '{8, 9, 12, 4, 5, 7, 1, 15, 35, 13, 10, 43};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_word(int mn, int s, int t, int d, int sh, int im);
    longint w;
    if (mn < 12) begin
      if (mn == 11) begin
        t = 0; d = 0; sh = 0;
      end else if (mn >= 7 && mn <= 9) begin
        s = 0;
      end else begin
        sh = 0;
      end
      w = longint'(s) * 64'd2097152 + longint'(t) * 64'd65536 + longint'(d) * 64'd2048
        + longint'(sh) * 64'd64 + longint'(FN_TAB[mn]);
    end else begin
      if (mn == 19) s = 0;
      if (mn == 17) t = 0;
      if (mn == 18) t = 1;
      w = longint'(OP_TAB[mn - 12]) * 64'd67108864 + longint'(s) * 64'd2097152
        + longint'(t) * 64'd65536 + longint'(im);
    end
    return w[31:0];
  endfunction

  task automatic set_fields(input int mn, input int s, input int t, input int d,
                            input int sh, input int im);
    mnem  = mn[4:0];
    rs    = s[4:0];
    rt    = t[4:0];
    rd    = d[4:0];
    shamt = sh[4:0];
    imm   = im[15:0];
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr = BASE_ADDR; m_count = 0; m_err = 1'b0;
    check_eq("start_count", count, 0);
    check_eq("start_addr", imem_addr, BASE_ADDR);
    check_eq("start_err", err, 0);
    check_eq("start_full", full, 0);
    check_eq("start_busy", busy, 1);
    check_eq("start_rdy", in_ready, 1);
  endtask

  // One handshake; for a legal word, stall the ack 'stall' cycles, optionally stop mid-write
  task automatic send(input int mn, input int s, input int t, input int d, input int sh,
                      input int im, input int stall, input bit stop_mid);
    logic [31:0] exp;
    check_eq("rdy_before", in_ready, 1);
    set_fields(mn, s, t, d, sh, im);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (mn >= 24) begin
      m_err = 1'b1;
      check_eq("ill_err", err, 1);
      check_eq("ill_no_we", imem_we, 0);
      check_eq("ill_count", count, m_count);
      check_eq("ill_rdy", in_ready, 1);
    end else begin
      exp = ref_word(mn, s, t, d, sh, im);
      last_wdata = imem_wdata;
      check_eq("we", imem_we, 1);
      check_eq("wdata", imem_wdata, exp);
      check_eq("addr", imem_addr, m_addr);
      check_eq("rdy_in_write", in_ready, 0);
      for (int i = 0; i < stall; i++) begin
        if (stop_mid && i == 0) stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("we_hold", imem_we, 1);
        check_eq("addr_hold", imem_addr, m_addr);
        check_eq("data_hold", imem_wdata, exp);
      end
      if (stop_mid && stall == 0) stop = 1'b1;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      stop = 1'b0;
      m_count++;
      m_addr = (m_addr + 4) % (1 << ADDR_W);
      check_eq("we_drop", imem_we, 0);
      check_eq("count", count, m_count);
      check_eq("addr_next", imem_addr, m_addr);
      if (stop_mid) begin
        check_eq("stop_busy", busy, 0);
        check_eq("stop_rdy", in_ready, 0);
      end else if (m_count == DEPTH) begin
        check_eq("full", full, 1);
        check_eq("full_rdy", in_ready, 0);
      end else begin
        check_eq("rdy_again", in_ready, 1);
        check_eq("not_full", full, 0);
      end
    end
    check_eq("err_sticky", err, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_eq("rst_rdy", in_ready, 0);
    check_eq("rst_we", imem_we, 0);
    check_eq("rst_addr", imem_addr, BASE_ADDR);
    check_eq("rst_wdata", imem_wdata, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_err", err, 0);
    rst_n = 1'b1;

    // in_valid in IDLE is ignored
    set_fields(0, 1, 2, 3, 9, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("idle_no_we", imem_we, 0);
    check_eq("idle_rdy", in_ready, 0);

    // Session A: fill to DEPTH, with an illegal mnemonic in the middle
    start_session();
    send(0, 1, 2, 3, 9, 0, 0, 1'b0);
    check_eq("tp_add", last_wdata, 32'h0022_1820);
    send(12, 0, 8, 0, 0, 'h0005, 1, 1'b0);
    check_eq("tp_addi", last_wdata, 32'h2008_0005);
    send(20, 29, 9, 0, 0, 'h0004, 0, 1'b0);
    check_eq("tp_lw", last_wdata, 32'h8FA9_0004);
    send(27, 3, 3, 3, 3, 'h1234, 0, 1'b0);
    send(7, 7, 1, 2, 4, 0, 0, 1'b0);
    check_eq("tp_sll", last_wdata, 32'h0001_1100);
    check_eq("tp_wrap_addr", imem_addr, 'h008);

    // FULL ignores in_valid
    set_fields(1, 1, 1, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("full_no_we", imem_we, 0);
    check_eq("full_count", count, DEPTH);
    check_eq("full_hold", full, 1);

    // Session B: stalled write, then start aborts a stalled write
    start_session();
    send(18, 4, 31, 0, 0, 'hFFFE, 3, 1'b0);
    check_eq("tp_bgez", last_wdata, 32'h0481_FFFE);
    set_fields(13, 5, 6, 0, 0, 'h00FF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("abort_we_pre", imem_we, 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr = BASE_ADDR; m_count = 0; m_err = 1'b0;
    check_eq("abort_we", imem_we, 0);
    check_eq("abort_count", count, 0);
    check_eq("abort_addr", imem_addr, BASE_ADDR);
    check_eq("abort_rdy", in_ready, 1);

    // Deferred stop in WRITE, then stop in RUN from a fresh session
    send(21, 2, 3, 0, 0, 'hABCD, 2, 1'b1);
    start_session();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("run_stop_busy", busy, 0);
    check_eq("run_stop_rdy", in_ready, 0);

    // Reset mid-write drops imem_we at the next edge
    start_session();
    set_fields(2, 1, 1, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst_mid_we", imem_we, 0);
    check_eq("rst_mid_count", count, 0);

    // Randomized sessions
    for (int sess = 0; sess < 80; sess++) begin
      int n;
      start_session();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        int mn;
        bit sm;
        if (m_count == DEPTH) begin
          set_fields($urandom_range(0, 23), 0, 0, 0, 0, 0);
          in_valid = 1'b1;
          tick();
          in_valid = 1'b0;
          check_eq("rnd_full_no_we", imem_we, 0);
          check_eq("rnd_full_count", count, DEPTH);
          break;
        end
        mn = $urandom_range(0, 31);
        sm = ($urandom_range(0, 7) == 0) && (mn < 24);
        send(mn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 2), sm);
        if (sm) break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
